// File: rtl/image_bc_adjust.sv
// image_bc_adjust - per-pixel contrast gain about MID plus brightness offset,
// saturated to DW bits, over CH channels. Three-stage pipeline with matching
// delay on video timing. Settings are taken through a valid/ready handshake
// and only become active at the next rising edge of i_vs, so that a single
// frame is never split between two sets of settings.
//
// Ports:
//   clk, rst             pixel clock, asynchronous active-high reset
//   i_vs, i_de, i_data   input video timing and pixel (channel k at k*DW)
//   cfg_valid/cfg_ready  settings handshake; cfg_ready is low while pending
//   cfg_bright           brightness code, offset = cfg_bright - BIAS
//   cfg_gain             contrast gain, unsigned with FRAC fractional bits
//   cfg_bypass           pass pixels through unmodified
//   cfg_pending          accepted settings are waiting for a frame start
//   o_vs, o_de, o_data   outputs, delayed by exactly 3 cycles
module image_bc_adjust #(
  parameter int DW   = 8,
  parameter int CH   = 3,
  parameter int GW   = 8,
  parameter int FRAC = 4,
  parameter int BIAS = 100,
  parameter int MID  = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic [CH*DW-1:0]   i_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [7:0]         cfg_bright,
  input  logic [GW-1:0]      cfg_gain,
  input  logic               cfg_bypass,
  output logic               cfg_pending,
  output logic               o_vs,
  output logic               o_de,
  output logic [CH*DW-1:0]   o_data
);

  localparam int DDW = DW + 1;        // centred pixel width
  localparam int PW  = DW + GW + 2;   // product width
  localparam int SW  = PW + 1;        // sum width, wide enough to never wrap
  localparam int OW  = 10;            // brightness offset width
  localparam logic signed [SW-1:0] S_MAX = SW'((1 << DW) - 1);

  // Settings: pending slot and active set
  logic          vs_d;
  logic          pending;
  logic [7:0]    pend_bright, act_bright;
  logic [GW-1:0] pend_gain, act_gain;
  logic          pend_bypass, act_bypass;
  logic          frame_start;
  logic          cfg_accept;

  assign frame_start = i_vs & ~vs_d;
  assign cfg_accept  = cfg_valid & ~pending;
  assign cfg_ready   = ~pending;
  assign cfg_pending = pending;

  // Apply and capture are mutually exclusive because capture needs
  // pending=0 and apply needs pending=1; a capture on a frame-start cycle
  // therefore waits for the following frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d        <= 1'b0;
      pending     <= 1'b0;
      pend_bright <= '0;
      pend_gain   <= '0;
      pend_bypass <= 1'b0;
      act_bright  <= 8'(BIAS);
      act_gain    <= GW'(1 << FRAC);
      act_bypass  <= 1'b0;
    end else begin
      vs_d <= i_vs;
      if (frame_start && pending) begin
        act_bright <= pend_bright;
        act_gain   <= pend_gain;
        act_bypass <= pend_bypass;
        pending    <= 1'b0;
      end else if (cfg_accept) begin
        pend_bright <= cfg_bright;
        pend_gain   <= cfg_gain;
        pend_bypass <= cfg_bypass;
        pending     <= 1'b1;
      end
    end
  end

  // Pipeline registers
  logic signed [DDW-1:0] d1 [CH];
  logic signed [OW-1:0]  off1, off2;
  logic [GW-1:0]         gain1;
  logic                  byp1, byp2;
  logic [CH*DW-1:0]      raw1, raw2;
  logic                  vs1, vs2, de1, de2;
  logic signed [PW-1:0]  p2 [CH];

  // Settings travel with the pixel so every stage sees the same set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        d1[k] <= '0;
        p2[k] <= '0;
      end
      off1  <= '0;
      off2  <= '0;
      gain1 <= '0;
      byp1  <= 1'b0;
      byp2  <= 1'b0;
      raw1  <= '0;
      raw2  <= '0;
      vs1   <= 1'b0;
      vs2   <= 1'b0;
      de1   <= 1'b0;
      de2   <= 1'b0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        d1[k] <= $signed({1'b0, i_data[k*DW +: DW]}) - $signed(DDW'(MID));
        p2[k] <= PW'(d1[k]) * $signed(PW'({1'b0, gain1}));
      end
      off1  <= $signed({{(OW-8){1'b0}}, act_bright}) - $signed(OW'(BIAS));
      gain1 <= act_gain;
      byp1  <= act_bypass;
      raw1  <= i_data;
      vs1   <= i_vs;
      de1   <= i_de;
      off2  <= off1;
      byp2  <= byp1;
      raw2  <= raw1;
      vs2   <= vs1;
      de2   <= de1;
    end
  end

  // Stage 3 arithmetic: arithmetic shift floors toward minus infinity,
  // then clamp on the full signed width.
  logic signed [SW-1:0] s3 [CH];
  logic [CH*DW-1:0]     proc;

  always_comb begin
    proc = '0;
    for (int k = 0; k < CH; k++) begin
      s3[k] = (SW'(p2[k]) >>> FRAC) + $signed(SW'(MID)) + SW'(off2);
      if (s3[k][SW-1])
        proc[k*DW +: DW] = '0;
      else if (s3[k] > S_MAX)
        proc[k*DW +: DW] = '1;
      else
        proc[k*DW +: DW] = s3[k][DW-1:0];
    end
  end

  // Blanking data and bypassed pixels pass through bit-exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vs   <= 1'b0;
      o_de   <= 1'b0;
      o_data <= '0;
    end else begin
      o_vs   <= vs2;
      o_de   <= de2;
      o_data <= (de2 && !byp2) ? proc : raw2;
    end
  end

endmodule

// File: tb/tb_image_bc_adjust.sv
module tb_image_bc_adjust;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vs, i_de;
  logic [23:0] i_data;
  logic        cfg_valid, cfg_ready, cfg_bypass, cfg_pending;
  logic [7:0]  cfg_bright, cfg_gain;
  logic        o_vs, o_de;
  logic [23:0] o_data;

  always #5 clk = ~clk;

  image_bc_adjust dut (
    .clk(clk), .rst(rst), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bright(cfg_bright),
    .cfg_gain(cfg_gain), .cfg_bypass(cfg_bypass), .cfg_pending(cfg_pending),
    .o_vs(o_vs), .o_de(o_de), .o_data(o_data)
  );

  logic [23:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every active output pixel pops one expected value.
  always @(negedge clk) begin
    if (!rst && o_de) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pixel: got %h expected none", o_data);
      end else begin
        check("pixel", {8'h0, o_data}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_de   = 1'b0;
    i_data = 24'h0;
    repeat (n) tick();
  endtask

  task automatic pix(input logic [23:0] d, input logic [23:0] e);
    i_de   = 1'b1;
    i_data = d;
    exp_q.push_back(e);
    tick();
    i_de   = 1'b0;
    i_data = 24'h0;
  endtask

  task automatic vs_pulse();
    i_vs = 1'b1;
    tick();
    tick();
    i_vs = 1'b0;
    tick();
  endtask

  task automatic cfg(input logic [7:0] b, input logic [7:0] g, input logic byp);
    cfg_valid  = 1'b1;
    cfg_bright = b;
    cfg_gain   = g;
    cfg_bypass = byp;
    check("cfg_ready_at_offer", {31'h0, cfg_ready}, 32'h1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic set_and_apply(input logic [7:0] b, input logic [7:0] g, input logic byp);
    cfg(b, g, byp);
    vs_pulse();
    idle(1);
  endtask

  initial begin
    rst = 1'b1; i_vs = 1'b0; i_de = 1'b0; i_data = 24'h0;
    cfg_valid = 1'b0; cfg_bright = 8'd0; cfg_gain = 8'd0; cfg_bypass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_vs", {31'h0, o_vs}, 32'h0);
    check("rst_o_de", {31'h0, o_de}, 32'h0);
    check("rst_o_data", {8'h0, o_data}, 32'h0);
    check("rst_cfg_ready", {31'h0, cfg_ready}, 32'h1);
    check("rst_cfg_pending", {31'h0, cfg_pending}, 32'h0);
    rst = 1'b0;
    tick();

    // 1: identity and 3-cycle timing lag
    i_vs = 1'b1; i_de = 1'b1; i_data = 24'h1080F0;
    exp_q.push_back(24'h1080F0);
    tick();
    i_de = 1'b0; i_data = 24'h0;
    tick();
    check("lag_de_edge2", {31'h0, o_de}, 32'h0);
    check("lag_vs_edge2", {31'h0, o_vs}, 32'h0);
    tick();
    check("lag_de_edge3", {31'h0, o_de}, 32'h1);
    check("lag_vs_edge3", {31'h0, o_vs}, 32'h1);
    check("identity_direct", {8'h0, o_data}, 32'h1080F0);
    i_vs = 1'b0;
    tick();
    check("lag_de_fall", {31'h0, o_de}, 32'h0);
    tick();
    check("lag_vs_hold", {31'h0, o_vs}, 32'h1);
    tick();
    check("lag_vs_fall", {31'h0, o_vs}, 32'h0);
    idle(3);

    // 2: brightness offset with high saturation
    set_and_apply(8'd150, 8'd16, 1'b0);
    pix(24'h1080F0, 24'h42B2FF);
    idle(3);

    // 3: gain 2.0, blanking passthrough, gain 1.5 floor rounding
    set_and_apply(8'd100, 8'd32, 1'b0);
    pix(24'h40A0F0, 24'h00C0FF);
    i_de = 1'b0; i_data = 24'hABCDEF;
    tick();
    i_data = 24'h0;
    tick();
    tick();
    check("blank_raw_data", {8'h0, o_data}, 32'hABCDEF);
    check("blank_raw_de", {31'h0, o_de}, 32'h0);
    idle(3);
    set_and_apply(8'd100, 8'd24, 1'b0);
    pix(24'h7F7F7F, 24'h7E7E7E);
    idle(3);

    // 4: negative offset, low clamp
    set_and_apply(8'd0, 8'd16, 1'b0);
    pix(24'h50C864, 24'h006400);
    idle(3);

    // 5: handshake
    cfg(8'd150, 8'd16, 1'b0);
    check("pend_ready_low", {31'h0, cfg_ready}, 32'h0);
    check("pend_flag_high", {31'h0, cfg_pending}, 32'h1);
    pix(24'h1080F0, 24'h001C8C);
    cfg_valid = 1'b1; cfg_bright = 8'd100; cfg_gain = 8'd32; cfg_bypass = 1'b0;
    tick();
    tick();
    cfg_valid = 1'b0;
    check("second_offer_ignored", {31'h0, cfg_pending}, 32'h1);
    pix(24'h1080F0, 24'h001C8C);
    idle(3);
    i_vs = 1'b1;
    tick();
    check("apply_pending_clear", {31'h0, cfg_pending}, 32'h0);
    check("apply_ready_high", {31'h0, cfg_ready}, 32'h1);
    tick();
    i_vs = 1'b0;
    tick();
    pix(24'h1080F0, 24'h42B2FF);
    idle(3);
    i_vs = 1'b1;
    cfg_valid = 1'b1; cfg_bright = 8'd100; cfg_gain = 8'd32; cfg_bypass = 1'b0;
    tick();
    cfg_valid = 1'b0;
    check("coincide_pending", {31'h0, cfg_pending}, 32'h1);
    tick();
    i_vs = 1'b0;
    tick();
    pix(24'h40A0F0, 24'h72D2FF);
    idle(3);
    vs_pulse();
    check("coincide_applied", {31'h0, cfg_pending}, 32'h0);
    pix(24'h40A0F0, 24'h00C0FF);
    idle(3);

    // 6: bypass, then reset mid-frame
    set_and_apply(8'd100, 8'd32, 1'b1);
    pix(24'h40A0F0, 24'h40A0F0);
    pix(24'h7F0080, 24'h7F0080);
    idle(3);
    cfg(8'd0, 8'd32, 1'b0);
    check("pre_rst_pending", {31'h0, cfg_pending}, 32'h1);
    i_de = 1'b1; i_data = 24'h123456;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_o_data", {8'h0, o_data}, 32'h0);
    check("midrst_o_de", {31'h0, o_de}, 32'h0);
    check("midrst_pending", {31'h0, cfg_pending}, 32'h0);
    check("midrst_ready", {31'h0, cfg_ready}, 32'h1);
    exp_q.delete();
    i_de = 1'b0; i_data = 24'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    vs_pulse();
    pix(24'h1080F0, 24'h1080F0);
    pix(24'h50C864, 24'h50C864);
    idle(5);

    check("queue_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
